// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port between two requesters (0 = CPU data port,
//   1 = loader / debug DMA). Each requester uses a req/ack handshake; ties are
//   broken round-robin. Each access holds the memory strobes for WAIT_CYCLES
//   cycles, followed by one cycle that carries the completion ack.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   req/wr/addr/wdata{0,1}  requester inputs, held stable while req is high
//   ack{0,1}                one-cycle completion pulse to each requester
//   rdata{0,1}              read data per requester, held until that
//                           requester's next read completes
//   mem_address, mem_wdata  latched address / write data to the memory
//   mem_rdata               memory read data, sampled on the last access cycle
//   mem_en, mem_wr          memory access / write strobes
//   busy                    high whenever an access is in progress or acking
module dmem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter is loaded with WAIT_CYCLES-1 so the access lasts WAIT_CYCLES cycles.
    localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES - 1);

    state_t        state;
    logic [7:0]    cnt;
    logic          last_grant;
    logic          owner;
    logic          wr_flag;

    logic          grant_any;
    logic          pick;
    logic          pick_wr;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

    // Winner selection: a lone requester always wins; on a tie the requester
    // that was not granted last time wins.
    always_comb begin
        grant_any  = req0 | req1;
        pick       = 1'b0;
        if (req0 && req1)
            pick = ~last_grant;
        else
            pick = req1;
        pick_wr    = pick ? wr1    : wr0;
        pick_addr  = pick ? addr1  : addr0;
        pick_wdata = pick ? wdata1 : wdata0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            wr_flag     <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner       <= pick;
                        last_grant  <= pick;
                        wr_flag     <= pick_wr;
                        mem_address <= pick_addr;
                        mem_wdata   <= pick_wdata;
                        cnt         <= CNT_INIT;
                        mem_en      <= 1'b1;
                        mem_wr      <= pick_wr;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        // Last access cycle: reads land only in the owner's register.
                        if (!wr_flag) begin
                            if (owner)
                                rdata1 <= mem_rdata;
                            else
                                rdata0 <= mem_rdata;
                        end
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        ack0   <= ~owner;
                        ack1   <= owner;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Two instances share the requester inputs:
// dut_a runs with WAIT_CYCLES=1, dut_b with WAIT_CYCLES=3.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, wr0, req1, wr1;
    logic [31:0] addr0, wdata0, addr1, wdata1, mem_rdata;

    logic        ack0_a, ack1_a, mem_en_a, mem_wr_a, busy_a;
    logic [31:0] rdata0_a, rdata1_a, mem_address_a, mem_wdata_a;
    logic        ack0_b, ack1_b, mem_en_b, mem_wr_b, busy_b;
    logic [31:0] rdata0_b, rdata1_b, mem_address_b, mem_wdata_b;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.WAIT_CYCLES(1), .AW(32), .DW(32)) dut_a (
        .clock(clock), .reset(reset),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_a), .rdata0(rdata0_a),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_a), .rdata1(rdata1_a),
        .mem_address(mem_address_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata),
        .mem_en(mem_en_a), .mem_wr(mem_wr_a), .busy(busy_a)
    );

    dmem_arbiter #(.WAIT_CYCLES(3), .AW(32), .DW(32)) dut_b (
        .clock(clock), .reset(reset),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b), .rdata1(rdata1_b),
        .mem_address(mem_address_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
        .mem_en(mem_en_b), .mem_wr(mem_wr_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int k = 0; k < 20 && !idle; k++) begin
            @(negedge clock);
            idle = !busy_a && !busy_b;
        end
        chk("idle_reached", {63'd0, idle}, 64'd1);
    endtask

    initial begin
        int en_cnt, ack_cnt, ack_idx, nacks, both;
        logic [31:0] seen_addr, seen_data;
        int ack_who[$];
        int ack_at[$];

        reset = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0; mem_rdata = '0;

        // Reset held for two edges with req0 asserted
        @(negedge clock);
        @(negedge clock);
        chk("rst_ack0",  ack0_a,  1'b0);
        chk("rst_ack1",  ack1_b,  1'b0);
        chk("rst_en",    {mem_en_a, mem_en_b, mem_wr_a, mem_wr_b}, 4'b0);
        chk("rst_busy",  {busy_a, busy_b}, 2'b0);
        chk("rst_addr",  mem_address_b, 32'h0);
        chk("rst_wdata", mem_wdata_a, 32'h0);
        chk("rst_rdata", {rdata0_a, rdata1_b}, 64'h0);

        // Tie right after reset -> requester 0 wins; WAIT_CYCLES=1 read
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0;
        addr0 = 32'h10; addr1 = 32'h99; mem_rdata = 32'hDEADBEEF;
        @(negedge clock);
        chk("rd_en",    mem_en_a, 1'b1);
        chk("rd_wr",    mem_wr_a, 1'b0);
        chk("rd_addr",  mem_address_a, 32'h10);
        chk("rd_busy",  busy_a, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        chk("rd_ack0",   ack0_a, 1'b1);
        chk("rd_ack1",   ack1_a, 1'b0);
        chk("rd_en_off", mem_en_a, 1'b0);
        chk("rd_rdata0", rdata0_a, 32'hDEADBEEF);
        chk("rd_rdata1", rdata1_a, 32'h0);
        @(negedge clock);
        chk("rd_ack_one", ack0_a, 1'b0);
        chk("rd_idle",    busy_a, 1'b0);
        wait_idle();
        chk("rd_b_rdata0", rdata0_b, 32'hDEADBEEF);

        // WAIT_CYCLES=3 write from requester 1
        mem_rdata = 32'hBAD0BAD0;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
        en_cnt = 0; ack_cnt = 0; ack_idx = -1; seen_addr = '0; seen_data = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mem_en_b && mem_wr_b) begin
                en_cnt++;
                seen_addr = mem_address_b;
                seen_data = mem_wdata_b;
            end
            if (ack1_b) begin
                ack_cnt++;
                ack_idx = i;
            end
            if (i == 0) req1 = 1'b0;
        end
        chk("wr_en_cycles", en_cnt, 3);
        chk("wr_ack_count", ack_cnt, 1);
        chk("wr_ack_time",  ack_idx, 3);
        chk("wr_addr",      seen_addr, 32'h20);
        chk("wr_data",      seen_data, 32'h12345678);
        chk("wr_rdata0_b",  rdata0_b, 32'hDEADBEEF);
        chk("wr_rdata1_b",  rdata1_b, 32'h0);
        chk("wr_rdata0_a",  rdata0_a, 32'hDEADBEEF);
        wr1 = 1'b0;
        wait_idle();

        // Contention on dut_a: both held high, expect 0,1,0,1 every 3 cycles
        req0 = 1'b1; req1 = 1'b1; mem_rdata = 32'h0000CAFE;
        both = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if ((ack0_a && ack1_a) || (ack0_b && ack1_b)) both++;
            if (ack0_a) begin ack_who.push_back(0); ack_at.push_back(i); end
            if (ack1_a) begin ack_who.push_back(1); ack_at.push_back(i); end
        end
        req0 = 1'b0; req1 = 1'b0;
        nacks = ack_who.size();
        chk("rr_count", nacks, 4);
        chk("rr_both",  both, 0);
        if (nacks == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rr_order%0d", k), ack_who[k], k % 2);
                chk($sformatf("rr_time%0d", k), ack_at[k], 1 + 3 * k);
            end
        end
        chk("rr_rdata1_a", rdata1_a, 32'h0000CAFE);
        wait_idle();

        // Mid-access changes on dut_b: addr change and req drop are ignored
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h30; mem_rdata = 32'h0BADF00D;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 0) begin
                addr0 = 32'h44; req0 = 1'b0; wr0 = 1'b1;
            end
            if (i == 1) begin
                chk("mid_addr", mem_address_b, 32'h30);
                chk("mid_wr",   mem_wr_b, 1'b0);
            end
            if (ack0_b) ack_cnt++;
            if (i == 3) begin
                chk("mid_ack0",  ack0_b, 1'b1);
                chk("mid_rdata", rdata0_b, 32'h0BADF00D);
            end
            if (i == 5) begin
                chk("mid_no_req",  busy_b, 1'b0);
                chk("mid_hold_addr", mem_address_b, 32'h30);
            end
        end
        chk("mid_ack_count", ack_cnt, 1);
        wr0 = 1'b0;
        wait_idle();

        // Reset during the 2nd of 3 access cycles on dut_b
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h50;
        @(negedge clock);
        req1 = 1'b0;
        @(negedge clock);
        chk("rst_mid_en_before", mem_en_b, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_strobes", {mem_en_b, mem_wr_b}, 2'b0);
        chk("rst_mid_busy",    busy_b, 1'b0);
        chk("rst_mid_ack",     {ack0_b, ack1_b}, 2'b0);
        reset = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ack0_b || ack1_b || busy_b) ack_cnt++;
        end
        chk("rst_mid_no_ack", ack_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (address, write data, read data, write strobe) between two requesters.
- Requester 0 is the CPU data port; requester 1 is the program/data loader or debug DMA.
- Each requester uses a req/ack handshake. Arbitration is round-robin, and the memory access takes a parameterised number of wait cycles.
- Sits between the processor data bus and the data memory at top level.

Parameters:
- WAIT_CYCLES, 1, number of cycles the memory strobes are held per access; legal range 1..255.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 access request, held until ack0
- wr0  in  1  requester 0: 1 = write, 0 = read; stable while req0
- addr0  in  AW  requester 0 address; stable while req0
- wdata0  in  DW  requester 0 write data; stable while req0
- ack0  out  1  one-cycle completion pulse to requester 0
- rdata0  out  DW  requester 0 read data, valid when ack0=1, held until next requester-0 read completes
- req1, wr1, addr1, wdata1, ack1, rdata1: same as above, for requester 1
- mem_address  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, sampled on the last access cycle
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write strobe
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - state=IDLE; ack0, ack1, mem_en, mem_wr and busy are 0.
  - mem_address, mem_wdata, rdata0 and rdata1 are 0.
  - wait counter is 0; last_grant=1, so requester 0 wins the first tie.
  - Reset mid-access aborts the access; mem_en and mem_wr are 0 from the following cycle. No ack is issued.
- State machine, three states:
  - IDLE:
    - No req: stay in IDLE.
    - One req: grant that requester.
    - Both req: grant the requester that is NOT last_grant.
    - On grant: latch addr, wdata and wr of the winner into mem_address, mem_wdata and the write flag; set owner and last_grant to the winner; counter=WAIT_CYCLES-1; go to ACCESS.
  - ACCESS:
    - mem_en=1; mem_wr equals the latched write flag.
    - If counter!=0, decrement and stay.
    - If counter==0: for a read, capture mem_rdata into the owner's rdata register; go to DONE.
  - DONE:
    - ack of the owner =1 for exactly this cycle; mem_en=mem_wr=0; go to IDLE.
- Latency: req sampled high in IDLE at edge T gives ACCESS in cycles T+1..T+WAIT_CYCLES and ack in cycle T+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Requester rule:
  - Deassert req (or present a new request) by the edge that ends the ack cycle.
  - req still high in the following IDLE cycle counts as a new request.
- Fairness:
  - Round-robin only applies on simultaneous requests.
  - With both requesters held high, grants strictly alternate 0,1,0,1...
- Request inputs are not resampled after grant:
  - Changes to addr, wdata or wr during ACCESS have no effect.
  - req dropped during ACCESS or DONE does not cancel the access; ack still pulses.
- Only one ack may be high in any cycle; ack0 and ack1 are never high together.
- The non-owner's rdata is never modified.
- Write accesses leave both rdata registers unchanged.
- mem_address and mem_wdata hold their last latched values in IDLE and DONE.

Test Plan:
- Reset: assert reset 2 cycles with req0=1 -> all outputs 0, busy=0. First grant after release goes to requester 0.
- Single read, WAIT_CYCLES=1: req0=1, wr0=0, addr0=0x00000010, memory returns 0xDEADBEEF -> mem_en high for 1 cycle with mem_address=0x10; ack0 pulses 2 cycles after req sampled; rdata0=0xDEADBEEF; rdata1 unchanged.
- Single write, WAIT_CYCLES=3: req1=1, wr1=1, addr1=0x20, wdata1=0x12345678 -> mem_en=mem_wr=1 for exactly 3 cycles with address 0x20 and data 0x12345678; ack1 pulses once; rdata0 and rdata1 unchanged.
- Contention: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1; never both acks high; each access completes in WAIT_CYCLES+2 cycles.
- Mid-access changes: change addr0 to 0x44 and drop req0 during ACCESS -> mem_address stays at the original value; ack0 still pulses; next IDLE sees no request.
- Reset mid-access: assert reset during the 2nd of 3 ACCESS cycles -> next cycle mem_en=mem_wr=0, state IDLE, no ack emitted.
